// File: rtl/mem_arbiter.sv
// Arbiter that lets the fetch (imem) and load/store (dmem) requesters share one memory port,
// with one transaction in flight. Optional imem anti-starvation: MEM_ARBITER_FAIRNESS_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              imem_req_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic              imem_gnt_o,
    output logic              imem_rvalid_o,
    output logic [DATA_W-1:0] imem_rdata_o,

    input  logic              dmem_req_i,
    input  logic              dmem_we_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic [1:0]        dmem_size_i,
    output logic              dmem_gnt_o,
    output logic              dmem_rvalid_o,
    output logic [DATA_W-1:0] dmem_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        mem_size_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] MEM_ACCESS_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              owner_dmem;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;

    logic              gnt_imem;
    logic              gnt_dmem;
    logic              resp;
    logic              force_imem;

`ifdef MEM_ARBITER_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign force_imem = (starve_cnt == LIMIT);

    // Counts dmem wins only while imem is actually waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (gnt_imem) begin
            starve_cnt <= '0;
        end else if (gnt_dmem) begin
            if (!imem_req_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign force_imem = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants and responses are blanked while reset is asserted.
    always_comb begin
        state_next = state;
        gnt_imem   = 1'b0;
        gnt_dmem   = 1'b0;
        resp       = 1'b0;
        mem_req_o  = 1'b0;
        case (state)
            IDLE: begin
                if (!reset_i) begin
                    if (imem_req_i && (!dmem_req_i || force_imem)) begin
                        gnt_imem   = 1'b1;
                        state_next = REQ;
                    end else if (dmem_req_i) begin
                        gnt_dmem   = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        resp       = !reset_i;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    resp       = !reset_i;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_dmem <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
        end else if (gnt_dmem) begin
            owner_dmem <= 1'b1;
            we_q       <= dmem_we_i;
            addr_q     <= dmem_addr_i;
            wdata_q    <= dmem_wdata_i;
            size_q     <= dmem_size_i;
        end else if (gnt_imem) begin
            owner_dmem <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= imem_addr_i;
            wdata_q    <= '0;
            size_q     <= MEM_ACCESS_SIZE_WORD;
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_size_o    = size_q;

    assign imem_gnt_o    = gnt_imem;
    assign dmem_gnt_o    = gnt_dmem;
    assign imem_rvalid_o = resp && !owner_dmem;
    assign dmem_rvalid_o = resp && owner_dmem;
    assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Define MEM_ARBITER_FAIRNESS_EN to check the anti-starvation build.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [1:0]        dmem_size;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .imem_req_i(imem_req),
        .imem_addr_i(imem_addr),
        .imem_gnt_o(imem_gnt),
        .imem_rvalid_o(imem_rvalid),
        .imem_rdata_o(imem_rdata),
        .dmem_req_i(dmem_req),
        .dmem_we_i(dmem_we),
        .dmem_addr_i(dmem_addr),
        .dmem_wdata_i(dmem_wdata),
        .dmem_size_i(dmem_size),
        .dmem_gnt_o(dmem_gnt),
        .dmem_rvalid_o(dmem_rvalid),
        .dmem_rdata_o(dmem_rdata),
        .mem_req_o(mem_req),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_size_o(mem_size),
        .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one outstanding transaction, issued then accepted then answered.
    logic              m_busy = 1'b0;
    logic              m_acc = 1'b0;
    logic              m_own_d = 1'b0;
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [1:0]        m_size = '0;
    int                m_cnt = 0;

    // Per-cycle samples for directed expectations.
    logic              s_ig, s_dg, s_irv, s_drv, s_mreq, s_mwe;
    logic [DATA_W-1:0] s_ird, s_drd, s_mwdata;
    logic [ADDR_W-1:0] s_maddr;
    logic [1:0]        s_msize;
    logic              e_ig_last, e_dg_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic e_ig, e_dg, resp, force_i;
        @(negedge clk);
        force_i = 1'b0;
`ifdef MEM_ARBITER_FAIRNESS_EN
        force_i = (m_cnt == STARVE_LIMIT);
`endif
        e_ig = 1'b0;
        e_dg = 1'b0;
        resp = 1'b0;
        if (!reset) begin
            if (!m_busy) begin
                if (imem_req && (!dmem_req || force_i)) e_ig = 1'b1;
                else if (dmem_req) e_dg = 1'b1;
            end else if (!m_acc) begin
                resp = mem_gnt && mem_rvalid;
            end else begin
                resp = mem_rvalid;
            end
        end

        chk("imem_gnt", 64'(imem_gnt), 64'(e_ig));
        chk("dmem_gnt", 64'(dmem_gnt), 64'(e_dg));
        chk("imem_rvalid", 64'(imem_rvalid), 64'(resp && !m_own_d));
        chk("dmem_rvalid", 64'(dmem_rvalid), 64'(resp && m_own_d));
        chk("imem_rdata", 64'(imem_rdata), (resp && !m_own_d) ? 64'(mem_rdata) : 64'd0);
        chk("dmem_rdata", 64'(dmem_rdata), (resp && m_own_d) ? 64'(mem_rdata) : 64'd0);
        chk("mem_req", 64'(mem_req), 64'(m_busy && !m_acc));
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("mem_size", 64'(mem_size), 64'(m_size));

        s_ig = imem_gnt; s_dg = dmem_gnt; s_irv = imem_rvalid; s_drv = dmem_rvalid;
        s_ird = imem_rdata; s_drd = dmem_rdata; s_mreq = mem_req; s_mwe = mem_we;
        s_maddr = mem_addr; s_mwdata = mem_wdata; s_msize = mem_size;
        e_ig_last = e_ig; e_dg_last = e_dg;

        if (reset) begin
            m_busy = 1'b0; m_acc = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_size = '0; m_cnt = 0;
        end else if (e_dg) begin
            m_busy = 1'b1; m_acc = 1'b0; m_own_d = 1'b1; m_we = dmem_we;
            m_addr = dmem_addr; m_wdata = dmem_wdata; m_size = dmem_size;
            m_cnt = imem_req ? ((m_cnt < STARVE_LIMIT) ? m_cnt + 1 : m_cnt) : 0;
        end else if (e_ig) begin
            m_busy = 1'b1; m_acc = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
            m_addr = imem_addr; m_wdata = '0; m_size = SZ_WORD;
            m_cnt = 0;
        end else if (resp) begin
            m_busy = 1'b0;
        end else if (m_busy && !m_acc && mem_gnt) begin
            m_acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_size = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    int seq[10];
    int exp_seq[10];
    int n;

    initial begin
        quiet();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_mem_req", 64'(s_mreq), 64'd0);
        chk("reset_mem_addr", 64'(s_maddr), 64'd0);
        quiet();

        // 1: single fetch, granted at once, data two cycles later.
        imem_req = 1'b1; imem_addr = 32'h0001_0000;
        step();
        chk("t1_gnt", 64'(s_ig), 64'd1);
        imem_req = 1'b0; mem_gnt = 1'b1;
        step();
        chk("t1_mreq", 64'(s_mreq), 64'd1);
        chk("t1_maddr", 64'(s_maddr), 64'h0001_0000);
        chk("t1_msize", 64'(s_msize), 64'(SZ_WORD));
        chk("t1_mwe", 64'(s_mwe), 64'd0);
        mem_gnt = 1'b0;
        step();
        chk("t1_rv_early", 64'(s_irv), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t1_rv", 64'(s_irv), 64'd1);
        chk("t1_rdata", 64'(s_ird), 64'hDEAD_BEEF);
        quiet();
        step();

        // 2: both request; dmem first, imem granted right after dmem response.
        imem_req = 1'b1; imem_addr = 32'h0000_0100;
        dmem_req = 1'b1; dmem_addr = 32'h0000_2000; dmem_size = SZ_BYTE;
        step();
        chk("t2_dgnt", 64'(s_dg), 64'd1);
        chk("t2_igwait", 64'(s_ig), 64'd0);
        dmem_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A5;
        step();
        chk("t2_drv", 64'(s_drv), 64'd1);
        chk("t2_drd", 64'(s_drd), 64'hA5);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();
        chk("t2_igsub", 64'(s_ig), 64'd1);
        imem_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step();
        quiet();
        step();

        // 3: dmem write stalled by memory for three cycles.
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_3000;
        dmem_wdata = 32'h1234_5678; dmem_size = SZ_WORD;
        step();
        chk("t3_dgnt", 64'(s_dg), 64'd1);
        quiet();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_mreq", 64'(s_mreq), 64'd1);
            chk("t3_maddr", 64'(s_maddr), 64'h0000_3000);
            chk("t3_mwdata", 64'(s_mwdata), 64'h1234_5678);
            chk("t3_mwe", 64'(s_mwe), 64'd1);
            chk("t3_irv", 64'(s_irv), 64'd0);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        step();
        chk("t3_drv", 64'(s_drv), 64'd1);
        chk("t3_irv_end", 64'(s_irv), 64'd0);
        quiet();
        step();
        chk("t3_drv_once", 64'(s_drv), 64'd0);

        // 4: grant and response together, then a stray response in IDLE.
        imem_req = 1'b1; imem_addr = 32'h0000_0040;
        step();
        imem_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        chk("t4_irv", 64'(s_irv), 64'd1);
        chk("t4_ird", 64'(s_ird), 64'hCAFE_0001);
        mem_gnt = 1'b0;
        step();
        chk("t4_stray_i", 64'(s_irv), 64'd0);
        chk("t4_stray_d", 64'(s_drv), 64'd0);
        quiet();

        // 5: reset while waiting for the response, late response afterwards.
        dmem_req = 1'b1; dmem_addr = 32'h0000_4000;
        step();
        dmem_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; reset = 1'b1;
        step();
        chk("t5_rst_drv", 64'(s_drv), 64'd0);
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        chk("t5_late_drv", 64'(s_drv), 64'd0);
        chk("t5_late_mreq", 64'(s_mreq), 64'd0);
        chk("t5_late_addr", 64'(s_maddr), 64'd0);
        chk("t5_late_drd", 64'(s_drd), 64'd0);
        quiet();

        // 6: both held continuously with an always-ready memory.
        imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (n < 10 && (s_dg || s_ig)) begin
                seq[n] = s_dg ? 1 : 2;
                n++;
            end
        end
        for (int i = 0; i < 10; i++) exp_seq[i] = 1;
`ifdef MEM_ARBITER_FAIRNESS_EN
        exp_seq[4] = 2;
        exp_seq[9] = 2;
`endif
        chk("t6_count", 64'(n), 64'd10);
        for (int i = 0; i < 10; i++) chk("t6_order", 64'(seq[i]), 64'(exp_seq[i]));
        quiet();
        step();
        step();

        // Randomized traffic; requesters hold until granted, occasionally give up.
        for (int c = 0; c < 4000; c++) begin
            if (imem_req && !e_ig_last) begin
                if ($urandom_range(19) == 0) imem_req = 1'b0;
            end else begin
                imem_req = ($urandom_range(2) == 0);
                imem_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (dmem_req && !e_dg_last) begin
                if ($urandom_range(19) == 0) dmem_req = 1'b0;
            end else begin
                dmem_req = ($urandom_range(1) == 0);
                dmem_we = $urandom_range(1);
                dmem_addr = $urandom;
                dmem_wdata = $urandom;
                dmem_size = 2'($urandom_range(2));
            end
            mem_gnt = $urandom_range(1);
            mem_rvalid = ($urandom_range(2) == 0);
            mem_rdata = $urandom;
            reset = ($urandom_range(299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
